// File: rtl/irq_ctrl_n.sv
// Fixed-priority interrupt controller: N_SRC level/edge sources, one held vector, bus-mapped CSRs.
// Optional build macro IRQ_SYNC_EN adds a 2-flop synchroniser on every irq_src bit.
module irq_ctrl_n #(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned VEC_W = 4,
    parameter int unsigned ADDR_W = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h0000_2100),
    parameter logic [N_SRC-1:0] RESET_ENABLE = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_src,
    output logic [VEC_W-1:0]  interrupt_vector,
    input  logic              interrupt_ack,
    input  logic [ADDR_W-1:0] bus_address,
    input  logic [63:0]       bus_write_data,
    input  logic              bus_write_enable,
    input  logic              bus_read_enable,
    output logic [63:0]       bus_read_data,
    output logic              irq_any
);

    localparam int unsigned DATA_W = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_GAP     = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   enable_q, enable_d;
    logic [N_SRC-1:0]   mode_q, mode_d;
    logic [N_SRC-1:0]   hist_q;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               irq_any_q;

    logic [N_SRC-1:0]   src_c;
    logic [N_SRC-1:0]   elig_c;
    logic [N_SRC-1:0]   w1c_c;
    logic [N_SRC-1:0]   ack_clr_c;
    logic [N_SRC-1:0]   edge_next_c;
    logic [VEC_W-1:0]   lo_idx_c;
    logic               cur_elig_c;
    logic               sel_c, wr_c, rd_c;
    logic [1:0]         off_c;
    logic               unused_bits_c;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0]   sync1_q, sync2_q;

    // Two-stage synchroniser for asynchronous sources
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_c = sync2_q;
`else
    assign src_c = irq_src;
`endif

    assign sel_c  = (bus_address[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
    assign off_c  = bus_address[4:3];
    assign wr_c   = sel_c && bus_write_enable;
    assign rd_c   = sel_c && bus_read_enable && !bus_write_enable;
    assign w1c_c  = (wr_c && off_c == 2'd0) ? bus_write_data[N_SRC-1:0] : '0;
    assign elig_c = pending_q & enable_q;
    assign cur_elig_c = |(elig_c & (N_SRC'(1) << idx_q));
    assign unused_bits_c = ^{bus_address[2:0], bus_write_data[DATA_W-1:N_SRC]};

    // Lowest set index wins
    always_comb begin
        lo_idx_c = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (elig_c[i]) lo_idx_c = VEC_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        idx_d     = idx_q;
        ack_clr_c = '0;
        case (state_q)
            S_IDLE: begin
                if (|elig_c) begin
                    idx_d   = lo_idx_c;
                    vec_d   = lo_idx_c + VEC_W'(1);
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (interrupt_ack) begin
                    ack_clr_c = N_SRC'(1) << idx_q;
                    vec_d     = '0;
                    state_d   = S_GAP;
                end else if (!cur_elig_c) begin
                    vec_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Edge sources: a new rising edge beats any clear landing on the same cycle
    always_comb begin
        edge_next_c = (src_c & ~hist_q) | (pending_q & ~(w1c_c | ack_clr_c));
        pending_d   = (mode_q & edge_next_c) | (~mode_q & src_c);
        enable_d    = enable_q;
        mode_d      = mode_q;
        rdata_d     = rdata_q;
        if (wr_c && off_c == 2'd1) enable_d = bus_write_data[N_SRC-1:0];
        if (wr_c && off_c == 2'd2) mode_d   = bus_write_data[N_SRC-1:0];
        if (rd_c) begin
            case (off_c)
                2'd0:    rdata_d = DATA_W'(pending_q);
                2'd1:    rdata_d = DATA_W'(enable_q);
                2'd2:    rdata_d = DATA_W'(mode_q);
                default: rdata_d = DATA_W'(vec_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            idx_q     <= '0;
            pending_q <= '0;
            enable_q  <= RESET_ENABLE;
            mode_q    <= '0;
            hist_q    <= '0;
            rdata_q   <= '0;
            irq_any_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            hist_q    <= src_c;
            rdata_q   <= rdata_d;
            irq_any_q <= |elig_c;
        end
    end

    assign interrupt_vector = vec_q;
    assign bus_read_data    = rdata_q;
    assign irq_any          = irq_any_q;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Scoreboard bench for irq_ctrl_n: expected vectors and read data are queued by stimulus, checked by a monitor.
module tb_irq_ctrl_n;

    localparam logic [63:0] BASE = 64'h0000_2100;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic        irq_any;

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_vec[$];
    logic [63:0] exp_rd[$];
    logic        mon_en = 1'b0;
    logic        rd_seen = 1'b0;
    logic [3:0]  last_vec = '0;

    irq_ctrl_n dut (
        .clk              (clk),
        .reset            (reset),
        .irq_src          (irq_src),
        .interrupt_vector (interrupt_vector),
        .interrupt_ack    (interrupt_ack),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_write_enable (bus_write_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_read_data    (bus_read_data),
        .irq_any          (irq_any)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // A selected read without a concurrent write produces data one cycle later
    always @(posedge clk)
        rd_seen <= bus_read_enable && !bus_write_enable && (bus_address[63:5] == BASE[63:5]);

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_seen) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", bus_read_data, 64'hDEAD);
                else chk("rd_data", bus_read_data, exp_rd.pop_front());
            end
            if (interrupt_vector !== last_vec) begin
                if (exp_vec.size() == 0) chk("vec_unexpected", 64'(interrupt_vector), 64'(last_vec));
                else chk("vec_seq", 64'(interrupt_vector), 64'(exp_vec.pop_front()));
                last_vec = interrupt_vector;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] off, input logic [63:0] data);
        bus_address      = BASE + off;
        bus_write_data   = data;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
    endtask

    task automatic rd(input logic [63:0] off, input logic [63:0] exp);
        exp_rd.push_back(exp);
        bus_address     = BASE + off;
        bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
    endtask

    initial begin
        int bad;
        reset            = 1'b1;
        irq_src          = '0;
        interrupt_ack    = 1'b0;
        bus_address      = '0;
        bus_write_data   = '0;
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        repeat (3) tick();
        chk("rst_vec", 64'(interrupt_vector), 64'd0);
        chk("rst_rdata", bus_read_data, 64'd0);
        chk("rst_irq_any", 64'(irq_any), 64'd0);
        mon_en = 1'b1;
        reset  = 1'b0;
        rd(64'h08, 64'h00FF);
        rd(64'h00, 64'h0);

        // Edge source 0: one-cycle pulse, held vector, ack
        wr(64'h10, 64'h01);
        irq_src = 8'h01; exp_vec.push_back(4'd1);
        tick();
        irq_src = 8'h00;
        tick();
        chk("edge0_vec", 64'(interrupt_vector), 64'd1);
        chk("edge0_irq_any", 64'(irq_any), 64'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (interrupt_vector !== 4'd1) bad++;
        end
        chk("edge0_hold", 64'(bad), 64'd0);
        interrupt_ack = 1'b1; exp_vec.push_back(4'd0);
        tick();
        interrupt_ack = 1'b0;
        chk("edge0_ack_gap", 64'(interrupt_vector), 64'd0);
        tick();
        chk("edge0_after_gap", 64'(interrupt_vector), 64'd0);
        rd(64'h00, 64'h0);

        // Level sources 2 and 5
        wr(64'h10, 64'h00);
        irq_src = 8'h24; exp_vec.push_back(4'd3);
        tick();
        tick();
        chk("lvl_vec3", 64'(interrupt_vector), 64'd3);
        interrupt_ack = 1'b1; exp_vec.push_back(4'd0); exp_vec.push_back(4'd3);
        tick();
        interrupt_ack = 1'b0;
        chk("lvl_gap", 64'(interrupt_vector), 64'd0);
        tick();
        chk("lvl_idle", 64'(interrupt_vector), 64'd0);
        tick();
        chk("lvl_represent", 64'(interrupt_vector), 64'd3);
        irq_src = 8'h20; interrupt_ack = 1'b1;
        exp_vec.push_back(4'd0); exp_vec.push_back(4'd6);
        tick();
        interrupt_ack = 1'b0;
        tick();
        tick();
        chk("lvl_vec6", 64'(interrupt_vector), 64'd6);

        // Disable the presented source: withdraw
        rd(64'h18, 64'h6);
        exp_vec.push_back(4'd0);
        wr(64'h08, 64'hDF);
        tick();
        chk("withdraw_vec", 64'(interrupt_vector), 64'd0);
        rd(64'h00, 64'h20);
        chk("withdraw_irq_any", 64'(irq_any), 64'd0);

        // Unselected window: reads hold, writes ignored
        bus_address = 64'h3000; bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
        chk("unsel_rd_hold", bus_read_data, 64'h20);
        bus_address = 64'h3008; bus_write_data = 64'h00; bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
        rd(64'h08, 64'hDF);

        // Edge source 1: new edge coincident with ack keeps it pending
        irq_src = 8'h00;
        tick();
        wr(64'h08, 64'hFF);
        wr(64'h10, 64'h02);
        irq_src = 8'h02; exp_vec.push_back(4'd2);
        tick();
        irq_src = 8'h00;
        tick();
        chk("edge1_vec", 64'(interrupt_vector), 64'd2);
        irq_src = 8'h02; interrupt_ack = 1'b1;
        exp_vec.push_back(4'd0); exp_vec.push_back(4'd2);
        tick();
        irq_src = 8'h00; interrupt_ack = 1'b0;
        chk("edge1_ack_vec", 64'(interrupt_vector), 64'd0);
        rd(64'h00, 64'h02);
        tick();
        chk("edge1_represent", 64'(interrupt_vector), 64'd2);
        interrupt_ack = 1'b1; exp_vec.push_back(4'd0);
        tick();
        interrupt_ack = 1'b0;
        tick();
        tick();
        rd(64'h00, 64'h0);

        // Synchronous reset while presenting vector 4
        irq_src = 8'h08; exp_vec.push_back(4'd4);
        tick();
        tick();
        chk("pre_rst_vec", 64'(interrupt_vector), 64'd4);
        reset = 1'b1; irq_src = 8'h00; exp_vec.push_back(4'd0);
        tick();
        reset = 1'b0;
        chk("mid_rst_vec", 64'(interrupt_vector), 64'd0);
        rd(64'h00, 64'h0);
        rd(64'h18, 64'h0);
        rd(64'h10, 64'h0);
        rd(64'h08, 64'hFF);

        // Ack in IDLE ignored; W1C withdraws an edge interrupt
        wr(64'h10, 64'h01);
        irq_src = 8'h01; exp_vec.push_back(4'd1);
        tick();
        irq_src = 8'h00; interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk("idle_ack_vec", 64'(interrupt_vector), 64'd1);
        rd(64'h00, 64'h01);
        exp_vec.push_back(4'd0);
        wr(64'h00, 64'h01);
        tick();
        chk("w1c_withdraw", 64'(interrupt_vector), 64'd0);
        rd(64'h00, 64'h0);

        // Write and read together: write lands, read data holds
        bus_address = BASE + 64'h08; bus_write_data = 64'h0F;
        bus_write_enable = 1'b1; bus_read_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0; bus_read_enable = 1'b0;
        chk("wr_rd_hold", bus_read_data, 64'h0);
        rd(64'h08, 64'h0F);

        repeat (3) tick();
        chk("vec_queue_drained", 64'(exp_vec.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
